input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 124 ++++++++++++
 tb/tb_input_debouncer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Two-channel switch debouncer: 2-flop synchronizer plus a stable-count filter per channel.
// Optional rise-pulse outputs are built when INPUT_DEBOUNCER_RISE_EN is defined.
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_db,
    output logic b_db
`ifdef INPUT_DEBOUNCER_RISE_EN
    ,
    output logic a_rise,
    output logic b_rise
`endif
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    logic [1:0] raw;
    logic [1:0] db;

    assign raw  = {b_raw, a_raw};
    assign a_db = db[0];
    assign b_db = db[1];

`ifdef INPUT_DEBOUNCER_RISE_EN
    logic [1:0] rise;

    assign a_rise = rise[0];
    assign b_rise = rise[1];
`endif

    // Channels share nothing; each generate instance owns its full pipeline.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        logic [0:0]       state_q;
        logic [0:0]       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             db_q;
        logic             db_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= raw[ch];
                sync2_q <= sync1_q;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            db_d    = db_q;
            case (state_q)
                ST_STABLE: begin
                    cnt_d = CNT_ZERO;
                    if (sync2_q != db_q) begin
                        state_d = ST_COUNTING;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_COUNTING: begin
                    if (sync2_q == db_q) begin
                        // Input fell back before the window closed: drop the glitch.
                        state_d = ST_STABLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STABLE;
                        cnt_d   = CNT_ZERO;
                        db_d    = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_STABLE;
                cnt_q   <= CNT_ZERO;
                db_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= db_d;
            end
        end

        assign db[ch] = db_q;

`ifdef INPUT_DEBOUNCER_RISE_EN
        logic rise_q;

        // Registered alongside db so the pulse lines up with the 0->1 edge of db.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rise_q <= 1'b0;
            end else begin
                rise_q <= db_d & ~db_q;
            end
        end

        assign rise[ch] = rise_q;
`endif
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with STABLE_CYCLES=4; rise checks only when
// INPUT_DEBOUNCER_RISE_EN is defined.
module tb_input_debouncer;

    localparam int unsigned SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b1;
    logic b_raw = 1'b1;
    logic a_db;
    logic b_db;
`ifdef INPUT_DEBOUNCER_RISE_EN
    logic a_rise;
    logic b_rise;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    input_debouncer #(
        .STABLE_CYCLES(SC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a_db  (a_db),
        .b_db  (b_db)
`ifdef INPUT_DEBOUNCER_RISE_EN
        ,
        .a_rise(a_rise),
        .b_rise(b_rise)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then return on the falling edge where inputs are driven and sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset with both inputs high; edges after deassert are numbered from 0.
        tick();
        tick();
        check("rst_a_db", a_db, 0);
        check("rst_b_db", b_db, 0);
        check("rst_a_cnt", dut.g_ch[0].cnt_q, 0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("post_rst_a_db_e%0d", i), a_db, (i >= 5) ? 1 : 0);
            check($sformatf("post_rst_b_db_e%0d", i), b_db, (i >= 5) ? 1 : 0);
`ifdef INPUT_DEBOUNCER_RISE_EN
            check($sformatf("post_rst_a_rise_e%0d", i), a_rise, (i == 5) ? 1 : 0);
            check($sformatf("post_rst_b_rise_e%0d", i), b_rise, (i == 5) ? 1 : 0);
`endif
        end

        // Drop a to 0; no rise pulse may appear on the falling transition.
        a_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("fall_a_db_e%0d", i), a_db, (i >= 5) ? 0 : 1);
`ifdef INPUT_DEBOUNCER_RISE_EN
            check($sformatf("fall_a_rise_e%0d", i), a_rise, 0);
`endif
        end

        // Clean 0->1 on a, first captured at edge 0: a_db rises after edge 5, b untouched.
        a_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rise_a_db_e%0d", i), a_db, (i >= 5) ? 1 : 0);
            check($sformatf("rise_b_db_e%0d", i), b_db, 1);
`ifdef INPUT_DEBOUNCER_RISE_EN
            check($sformatf("rise_a_rise_e%0d", i), a_rise, (i == 5) ? 1 : 0);
            check($sformatf("rise_b_rise_e%0d", i), b_rise, 0);
`endif
        end

        a_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_bounce_a_db", a_db, 0);

        // Bounce 1,0,1,0 then steady 1 from edge 4: a_db rises at edge 4+SC+1 = 9.
        for (int i = 0; i < 11; i++) begin
            a_raw = (i < 4) ? ((i % 2) == 0) : 1'b1;
            tick();
            check($sformatf("bounce_a_db_e%0d", i), a_db, (i >= 9) ? 1 : 0);
`ifdef INPUT_DEBOUNCER_RISE_EN
            check($sformatf("bounce_a_rise_e%0d", i), a_rise, (i == 9) ? 1 : 0);
`endif
        end

        // 3-cycle low glitch while a_db=1: counter climbs to 3 then clears, a_db holds.
        for (int i = 0; i < 9; i++) begin
            a_raw = (i < 3) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("glitch_a_db_e%0d", i), a_db, 1);
            check($sformatf("glitch_a_cnt_e%0d", i), dut.g_ch[0].cnt_q,
                  (i >= 2 && i <= 4) ? (i - 1) : 0);
        end

        a_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_midrst_a_db", a_db, 0);
        check("pre_midrst_b_db", b_db, 1);

        // Start counting on a, then reset at counter=2; reset must act without a clock edge.
        a_raw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("midrst_a_cnt_e%0d", i), dut.g_ch[0].cnt_q, (i >= 2) ? (i - 1) : 0);
        end
        rst = 1'b1;
        #1;
        check("midrst_async_a_db", a_db, 0);
        check("midrst_async_b_db", b_db, 0);
        check("midrst_async_a_cnt", dut.g_ch[0].cnt_q, 0);
        check("midrst_async_a_sync2", dut.g_ch[0].sync2_q, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("midrst_a_db_e%0d", i), a_db, (i >= 5) ? 1 : 0);
            check($sformatf("midrst_b_db_e%0d", i), b_db, (i >= 5) ? 1 : 0);
`ifdef INPUT_DEBOUNCER_RISE_EN
            check($sformatf("midrst_a_rise_e%0d", i), a_rise, (i == 5) ? 1 : 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
